mix_col_serial: RTL and testbench

- Byte-serial AES MixColumns / InvMixColumns engine in the cryptographic core.
- Sits directly downstream of the 8-bit data register.
- Collects one 4-byte state column, transforms it, and streams the 4 result bytes back out to the register-input mux.
- Counts columns, so the controller knows when a full AES state (COLUMNS columns) has passed through.

---
 rtl/mix_col_serial.sv | 144 ++++++++++++++
 tb/tb_mix_col_serial.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mix_col_serial.sv
// Byte-serial AES MixColumns / InvMixColumns engine. It gathers one 4-byte state
// column, transforms it in a single cycle and streams the four result bytes back out.
module mix_col_serial #(
   parameter int COLUMNS = 4,
   parameter int CNT_W   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inv,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       busy,
   output logic       block_done
);

   typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLUMNS - 1);

   state_t           state;
   state_t           state_next;
   logic [1:0]       idx;
   logic [CNT_W-1:0] col_cnt;
   logic             inv_q;
   logic             done_q;
   logic [7:0]       a      [4];
   logic [7:0]       r      [4];
   logic [7:0]       r_calc [4];
   logic             in_fire;
   logic             out_fire;
   logic             last_byte;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // One output byte of the column transform; b0 is the byte in the result's own row
   function automatic logic [7:0] mix_byte(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic inv_sel);
      logic [7:0] b  [4];
      logic [7:0] p2 [4];
      logic [7:0] p4 [4];
      logic [7:0] p8 [4];
      b[0] = b0;
      b[1] = b1;
      b[2] = b2;
      b[3] = b3;
      for (int i = 0; i < 4; i++) begin
         p2[i] = xtime(b[i]);
         p4[i] = xtime(p2[i]);
         p8[i] = xtime(p4[i]);
      end
      if (inv_sel)
         return (p8[0] ^ p4[0] ^ p2[0]) ^ (p8[1] ^ p2[1] ^ b[1]) ^
                (p8[2] ^ p4[2] ^ b[2]) ^ (p8[3] ^ b[3]);
      else
         return p2[0] ^ (p2[1] ^ b[1]) ^ b[2] ^ b[3];
   endfunction

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_byte = (idx == 2'd3);

   always_comb begin
      for (int i = 0; i < 4; i++)
         r_calc[i] = mix_byte(a[i], a[(i + 1) % 4], a[(i + 2) % 4], a[(i + 3) % 4], inv_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= LOAD;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (in_fire && last_byte) state_next = CALC;
         CALC:    state_next = SEND;
         SEND:    if (out_fire && last_byte) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      in_ready   = (state == LOAD);
      out_valid  = (state == SEND);
      out_data   = (state == SEND) ? r[idx] : 8'h00;
      busy       = (state != LOAD) || (idx != 2'd0);
      block_done = done_q;
   end

   // idx is shared between gathering and sending since the two never overlap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= 2'd0;
         col_cnt <= '0;
         inv_q   <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            a[i] <= 8'h00;
            r[i] <= 8'h00;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            LOAD: begin
               if (in_fire) begin
                  a[idx] <= in_data;
                  idx    <= idx + 2'd1;
                  if (idx == 2'd0)
                     inv_q <= inv;
               end
            end
            CALC: begin
               for (int i = 0; i < 4; i++)
                  r[i] <= r_calc[i];
            end
            SEND: begin
               if (out_fire) begin
                  idx <= idx + 2'd1;
                  if (last_byte) begin
                     if (col_cnt == LAST_COL) begin
                        col_cnt <= '0;
                        done_q  <= 1'b1;
                     end else begin
                        col_cnt <= col_cnt + 1'b1;
                     end
                  end
               end
            end
            default: idx <= 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_col_serial.sv
// Directed-vector bench for mix_col_serial using known AES MixColumns test columns.
module tb_mix_col_serial;

   logic       clk;
   logic       rst;
   logic       inv;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       busy;
   logic       block_done;

   int compareCount = 0;
   int failCount    = 0;
   int doneCount    = 0;

   logic [7:0] colDb    [4] = '{8'hdb, 8'h13, 8'h53, 8'h45};
   logic [7:0] colDbMix [4] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
   logic [7:0] colF2    [4] = '{8'hf2, 8'h0a, 8'h22, 8'h5c};
   logic [7:0] colF2Mix [4] = '{8'h9f, 8'hdc, 8'h58, 8'h9d};
   logic [7:0] colC6    [4] = '{8'hc6, 8'hc6, 8'hc6, 8'hc6};

   mix_col_serial #(.COLUMNS(4), .CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .inv        (inv),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .block_done (block_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (block_done === 1'b1) doneCount++;

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Feeds one column starting at a negedge in LOAD, returns at the negedge where SEND begins
   task automatic applyStimulus(input logic [7:0] col [4], input logic invFirst,
                                input logic invRest, input int maxGap, input string name);
      int t;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b0;
         inv      = (k == 0) ? invFirst : invRest;
         if (maxGap > 0) repeat ($urandom_range(0, maxGap)) @(negedge clk);
         t = 0;
         while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
         end
         checkOutput($sformatf("%s_in_ready%0d", name, k), {7'd0, in_ready}, 8'h01);
         in_valid = 1'b1;
         in_data  = col[k];
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput({name, "_calc_valid"}, {7'd0, out_valid}, 8'h00);
      checkOutput({name, "_calc_ready"}, {7'd0, in_ready}, 8'h00);
      @(negedge clk);
      checkOutput({name, "_latency"}, {7'd0, out_valid}, 8'h01);
   endtask

   // Drains four result bytes with an out_ready pattern (LSB first, then held high)
   task automatic receiveColumn(input logic [7:0] expCol [4], input logic [15:0] pattern,
                                input int patLen, input logic junkIn, input logic expDone,
                                input string name);
      int k = 0;
      int cyc = 0;
      int t = 0;
      logic stalled = 1'b0;
      logic [7:0] held = 8'h00;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      checkOutput({name, "_out_valid"}, {7'd0, out_valid}, 8'h01);
      while (k < 4 && cyc < 40) begin
         out_ready = (cyc < patLen) ? pattern[cyc] : 1'b1;
         in_valid  = junkIn;
         in_data   = 8'h77;
         checkOutput($sformatf("%s_byte%0d_c%0d", name, k, cyc), out_data, expCol[k]);
         checkOutput($sformatf("%s_send_ready_c%0d", name, cyc), {7'd0, in_ready}, 8'h00);
         if (stalled)
            checkOutput($sformatf("%s_hold_c%0d", name, cyc), out_data, held);
         stalled = !out_ready;
         held    = out_data;
         @(posedge clk);
         if (out_ready) k++;
         cyc++;
         @(negedge clk);
      end
      checkOutput({name, "_sent_all"}, 8'(k), 8'd4);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checkOutput({name, "_done"}, {7'd0, block_done}, {7'd0, expDone});
      checkOutput({name, "_busy"}, {7'd0, busy}, 8'h00);
      checkOutput({name, "_idle_valid"}, {7'd0, out_valid}, 8'h00);
      @(negedge clk);
      checkOutput({name, "_done_clear"}, {7'd0, block_done}, 8'h00);
   endtask

   initial begin
      rst       = 1'b1;
      inv       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", {7'd0, in_ready}, 8'h01);
      checkOutput("rst_out_valid", {7'd0, out_valid}, 8'h00);
      checkOutput("rst_out_data", out_data, 8'h00);
      checkOutput("rst_busy", {7'd0, busy}, 8'h00);
      checkOutput("rst_block_done", {7'd0, block_done}, 8'h00);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] forward column");
      applyStimulus(colDb, 1'b0, 1'b0, 0, "fwd");
      receiveColumn(colDbMix, 16'hffff, 0, 1'b0, 1'b0, "fwd");

      $display("[TB] inverse column with input gaps");
      applyStimulus(colDbMix, 1'b1, 1'b1, 3, "inv");
      receiveColumn(colDb, 16'hffff, 0, 1'b0, 1'b0, "inv");

      $display("[TB] output backpressure with in_valid held during SEND");
      applyStimulus(colF2, 1'b0, 1'b0, 0, "bp");
      receiveColumn(colF2Mix, 16'h0069, 7, 1'b1, 1'b0, "bp");

      $display("[TB] reset in the middle of SEND");
      applyStimulus(colDb, 1'b0, 1'b0, 0, "rstmid");
      out_ready = 1'b1;
      checkOutput("rstmid_b0", out_data, 8'h8e);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstmid_b1", out_data, 8'h4d);
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("rstmid_out_valid", {7'd0, out_valid}, 8'h00);
      checkOutput("rstmid_in_ready", {7'd0, in_ready}, 8'h01);
      checkOutput("rstmid_out_data", out_data, 8'h00);
      checkOutput("rstmid_busy", {7'd0, busy}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(colDb, 1'b0, 1'b0, 0, "fresh");
      receiveColumn(colDbMix, 16'hffff, 0, 1'b0, 1'b0, "fresh");

      $display("[TB] inv latched with byte 0 only");
      applyStimulus(colDb, 1'b0, 1'b1, 0, "latch");
      receiveColumn(colDbMix, 16'hffff, 0, 1'b0, 1'b0, "latch");

      applyStimulus(colC6, 1'b0, 1'b0, 0, "post3");
      receiveColumn(colC6, 16'hffff, 0, 1'b0, 1'b0, "post3");
      applyStimulus(colC6, 1'b0, 1'b0, 0, "post4");
      receiveColumn(colC6, 16'hffff, 0, 1'b0, 1'b1, "post4");

      $display("[TB] fixed point block of four columns");
      pulseReset();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(colC6, 1'b0, 1'b0, 0, $sformatf("c6col%0d", c));
         receiveColumn(colC6, 16'hffff, 0, 1'b0, (c == 3), $sformatf("c6col%0d", c));
      end
      checkOutput("final_busy", {7'd0, busy}, 8'h00);
      checkOutput("total_done_pulses", 8'(doneCount), 8'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
